// File: rtl/sound_bus_mixer.sv
// rtl/sound_bus_mixer.sv - multi-POKEY bus decode, gain registers and soft-mute audio mixer
// Optional readback of latch/gain registers: define SOUND_READBACK_EN.
module sound_bus_mixer #(
  parameter int                NUM_CH       = 2,
  parameter int                CH_W         = 4,
  parameter int                OUT_W        = 8,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] POKEY_BASE   = 16'h1820,
  parameter logic [ADDR_W-1:0] POKEY_STRIDE = 16'h0010,
  parameter logic [ADDR_W-1:0] LATCH_ADDR   = 16'h1840,
  parameter logic [ADDR_W-1:0] GAIN_BASE    = 16'h1850
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_en,
  input  logic                   we,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [7:0]             wdata,
  output logic [7:0]             rd_data,
  output logic [NUM_CH-1:0]      pokey_cs_n,
  input  logic [NUM_CH*CH_W-1:0] ch_audio,
  output logic [OUT_W-1:0]       audio_out,
  output logic                   audio_valid,
  output logic                   audiosel,
  output logic                   amp_on
);

  localparam int          SUM_W   = CH_W + 4 + $clog2(NUM_CH);
  localparam logic [31:0] SAT_MAX = (32'd1 << OUT_W) - 32'd1;

  typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} ramp_state_t;

  logic [7:0]             latch;
  logic [3:0]             gain [NUM_CH];
  logic [NUM_CH*CH_W-1:0] ch_q;
  logic [CH_W+3:0]        p_q [NUM_CH];
  logic                   v0_q, v1_q;
  logic [SUM_W-1:0]       sum_c;
  logic [OUT_W-1:0]       sat_c;
  logic [OUT_W+4:0]       prod_c;
  ramp_state_t            state_q, state_d;
  logic [4:0]             level_q, level_d;

  // Chip-select windows: offset from each window base, unsigned, must fall below 16
  always_comb begin
    logic [ADDR_W-1:0] off;
    off = '0;
    pokey_cs_n = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      off = addr - (POKEY_BASE + ADDR_W'(i) * POKEY_STRIDE);
      pokey_cs_n[i] = !(off < ADDR_W'(16));
    end
  end

  // Bus writes into the output latch and the per-channel gain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) gain[i] <= 4'hF;
    end else if (we) begin
      if (addr == LATCH_ADDR) latch <= wdata;
      for (int i = 0; i < NUM_CH; i++)
        if (addr == GAIN_BASE + ADDR_W'(i)) gain[i] <= wdata[3:0];
    end
  end

  assign audiosel = latch[0];

  // Sum of gained channels, clipped to the output range
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_CH; i++) sum_c = sum_c + SUM_W'(p_q[i]);
    sat_c  = (32'(sum_c) > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(sum_c);
    prod_c = (OUT_W+5)'(sat_c) * (OUT_W+5)'(level_q);
  end

  // Pipeline: capture on tick, gain multiply, then sum/saturate/ramp-scale into audio_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) p_q[i] <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      audio_valid <= 1'b0;
      audio_out   <= '0;
    end else begin
      if (sample_en) ch_q <= ch_audio;
      for (int i = 0; i < NUM_CH; i++)
        p_q[i] <= (CH_W+4)'(ch_q[i*CH_W +: CH_W]) * (CH_W+4)'(gain[i]);
      v0_q        <= sample_en;
      v1_q        <= v0_q;
      audio_valid <= v1_q;
      if (v1_q) audio_out <= OUT_W'(prod_c >> 4);
    end
  end

  // Ramp state and level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUTED;
      level_q <= 5'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Ramp next state: one level step per tick toward full scale or silence
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (sample_en) begin
      case (state_q)
        MUTED: if (latch[5]) begin
          state_d = RAMP_UP;
          level_d = 5'd1;
        end
        RAMP_UP: if (latch[5]) begin
          level_d = level_q + 5'd1;
          state_d = (level_q == 5'd15) ? ACTIVE : RAMP_UP;
        end else begin
          level_d = level_q - 5'd1;
          state_d = (level_q == 5'd1) ? MUTED : RAMP_DOWN;
        end
        ACTIVE: if (!latch[5]) begin
          state_d = RAMP_DOWN;
          level_d = 5'd15;
        end
        RAMP_DOWN: if (!latch[5]) begin
          level_d = level_q - 5'd1;
          state_d = (level_q == 5'd1) ? MUTED : RAMP_DOWN;
        end else begin
          level_d = level_q + 5'd1;
          state_d = (level_q == 5'd15) ? ACTIVE : RAMP_UP;
        end
        default: begin
          state_d = MUTED;
          level_d = 5'd0;
        end
      endcase
    end
  end

  // Ramp outputs: amplifier powered whenever any level is applied
  always_comb begin
    amp_on = (level_q != 5'd0);
  end

`ifdef SOUND_READBACK_EN
  logic [7:0] rd_c;

  // Readback mux over latch and gain registers; unmapped addresses read zero
  always_comb begin
    rd_c = 8'h00;
    if (addr == LATCH_ADDR) rd_c = latch;
    for (int i = 0; i < NUM_CH; i++)
      if (addr == GAIN_BASE + ADDR_W'(i)) rd_c = {4'h0, gain[i]};
  end

  // Read data registered one clock after the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else if (re) rd_data <= rd_c;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{re, latch};
  assign rd_data   = 8'h00;
`endif

endmodule

// File: tb/tb_sound_bus_mixer.sv
// tb/tb_sound_bus_mixer.sv - scoreboard bench for sound_bus_mixer
module tb_sound_bus_mixer;
  localparam int          NUM_CH = 2;
  localparam int          CH_W   = 4;
  localparam int          OUT_W  = 8;
  localparam logic [15:0] PBASE  = 16'h1820;
  localparam logic [15:0] LATCH  = 16'h1840;
  localparam logic [15:0] GBASE  = 16'h1850;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   sample_en = 1'b0, we = 1'b0, re = 1'b0;
  logic [15:0]            addr = 16'h0000;
  logic [7:0]             wdata = 8'h00;
  logic [7:0]             rd_data;
  logic [NUM_CH-1:0]      pokey_cs_n;
  logic [NUM_CH*CH_W-1:0] ch_audio = '0;
  logic [OUT_W-1:0]       audio_out;
  logic                   audio_valid, audiosel, amp_on;

  sound_bus_mixer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .OUT_W(OUT_W), .ADDR_W(16),
    .POKEY_BASE(PBASE), .POKEY_STRIDE(16'h0010), .LATCH_ADDR(LATCH), .GAIN_BASE(GBASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .rd_data(rd_data), .pokey_cs_n(pokey_cs_n),
    .ch_audio(ch_audio), .audio_out(audio_out), .audio_valid(audio_valid),
    .audiosel(audiosel), .amp_on(amp_on)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int exp_val_q[$];
  int exp_cyc_q[$];
  int latch_m, level_m;
  int gain_m [NUM_CH];
  int mon_v, mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic int exp_cs(input int a);
    int r = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      int lo = int'(PBASE) + 16 * i;
      if (!(a >= lo && a < lo + 16)) r |= (1 << i);
    end
    return r;
  endfunction

  function automatic int mix(input logic [7:0] ch);
    int s = 0;
    for (int i = 0; i < NUM_CH; i++) s += ((int'(ch) >> (i * CH_W)) & 15) * gain_m[i];
    if (s > 255) s = 255;
    return (s * level_m) / 16;
  endfunction

  function automatic int rd_model(input int a);
    if (a == int'(LATCH)) return latch_m;
    for (int i = 0; i < NUM_CH; i++) if (a == int'(GBASE) + i) return gain_m[i];
    return 0;
  endfunction

  task automatic model_reset();
    latch_m = 0;
    level_m = 0;
    for (int i = 0; i < NUM_CH; i++) gain_m[i] = 15;
  endtask

  // One bus cycle: drive after a falling edge, update the model, check after the next falling edge
  task automatic do_cycle(input logic se, input logic w, input logic r,
                          input logic [15:0] a, input logic [7:0] d, input logic [7:0] ch);
    int rd_exp;
    sample_en = se; we = w; re = r; addr = a; wdata = d; ch_audio = ch;
    #1 chk("cs_n", int'(pokey_cs_n), exp_cs(int'(a)));
    rd_exp = rd_model(int'(a));
    if (se) begin
      if ((latch_m & 8'h20) != 0) level_m = (level_m < 16) ? level_m + 1 : 16;
      else                       level_m = (level_m > 0)  ? level_m - 1 : 0;
      exp_val_q.push_back(mix(ch));
      exp_cyc_q.push_back(cyc);
    end
    if (w) begin
      if (int'(a) == int'(LATCH)) latch_m = int'(d);
      for (int i = 0; i < NUM_CH; i++) if (int'(a) == int'(GBASE) + i) gain_m[i] = int'(d) & 15;
    end
    @(negedge clk);
    chk("audiosel", int'(audiosel), latch_m & 1);
    chk("amp_on", int'(amp_on), (level_m > 0) ? 1 : 0);
`ifdef SOUND_READBACK_EN
    if (r) chk("rd_data", int'(rd_data), rd_exp);
`else
    chk("rd_data_zero", int'(rd_data), 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 1'b0, 16'h1800 + 16'($urandom_range(0, 127)), 8'h00, 8'($urandom));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    do_cycle(1'b0, 1'b1, 1'b0, a, d, 8'h00);
  endtask

  task automatic tick(input logic [7:0] ch);
    do_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, ch);
    idle(3);
  endtask

  task automatic tick_w(input logic [7:0] ch, input logic [7:0] d);
    do_cycle(1'b1, 1'b1, 1'b0, LATCH, d, ch);
    idle(3);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_val_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain", exp_val_q.size(), 0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding sample, 3 clk after its tick
  always @(negedge clk) begin
    if (rst_n && audio_valid) begin
      if (exp_val_q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_v = exp_val_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("audio_out", int'(audio_out), mon_v);
        chk("valid_latency", cyc - mon_c, 3);
      end
    end
  end

  initial begin
    logic [15:0] dec_tab [6];
    dec_tab[0] = 16'h1825; dec_tab[1] = 16'h1835; dec_tab[2] = 16'h1845;
    dec_tab[3] = 16'h181F; dec_tab[4] = 16'h1820; dec_tab[5] = 16'h183F;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_audio_out", int'(audio_out), 0);
    chk("rst_audio_valid", int'(audio_valid), 0);
    chk("rst_amp_on", int'(amp_on), 0);
    chk("rst_audiosel", int'(audiosel), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dec_tab[k]) do_cycle(1'b0, 1'b0, 1'b0, dec_tab[k], 8'h00, 8'h00);
    idle(8);

    tick(8'hFF);
    wr(LATCH, 8'h21);
    repeat (18) tick(8'hFF);

    wr(GBASE, 8'hF2);
    tick(8'h04);
    wr(GBASE, 8'h0F);
    tick(8'hFF);

    wr(LATCH, 8'h00);
    repeat (16) tick(8'hFF);
    wr(LATCH, 8'h20);
    repeat (6) tick(8'hFF);
    wr(LATCH, 8'h00);
    tick(8'h0F);
    repeat (5) tick(8'hFF);

    tick_w(8'hFF, 8'h20);
    tick(8'hFF);
    wr(LATCH, 8'h00);
    tick(8'hFF);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: wr(GBASE + 16'($urandom_range(0, 3)), 8'($urandom));
        1: wr(LATCH, 8'($urandom));
        2: tick_w(8'($urandom), 8'($urandom));
        default: tick(8'($urandom));
      endcase
    end

`ifdef SOUND_READBACK_EN
    do_cycle(1'b0, 1'b0, 1'b1, LATCH, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, GBASE, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, GBASE + 16'd1, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, GBASE + 16'd2, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 8'h00);
`endif

    wr(LATCH, 8'h00);
    wr(GBASE, 8'h0F);
    wr(GBASE + 16'd1, 8'h0F);
    repeat (16) tick(8'hFF);
    wr(LATCH, 8'h25);
    repeat (10) tick(8'hFF);
    drain();
    wr(GBASE, 8'h03);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_audio_out", int'(audio_out), 0);
    chk("async_amp_on", int'(amp_on), 0);
    chk("async_audiosel", int'(audiosel), 0);
    chk("async_valid", int'(audio_valid), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SOUND_READBACK_EN
    do_cycle(1'b0, 1'b0, 1'b1, GBASE + 16'd1, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, LATCH, 8'h00, 8'h00);
`endif
    wr(LATCH, 8'h20);
    tick(8'hFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d want=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
